// File: rtl/instr_encoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : instr_encoder_if                                          |
// | Purpose  : Field-bundle input, encoded-word output stream and error  |
// |            status for the RV32I instruction encoder.                 |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface instr_encoder_if #(
    parameter int ADDR_W = 12
);
    // Decoded-field input bundle
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        fmt;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [31:0]       imm;

    // Address counter control
    logic              load_addr;
    logic [ADDR_W-1:0] base_addr;

    // Encoded-word output stream
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;

    // Error reporting
    logic              err_sticky;
    logic [7:0]        err_count;
    logic              clear_err;

    // Producer / consumer side (test or boot sequencer)
    modport master (
        output in_valid, fmt, rd, rs1, rs2, funct3, imm,
        output load_addr, base_addr, out_ready, clear_err,
        input  in_ready, out_valid, out_instr, out_addr, err_sticky, err_count
    );

    // Encoder side
    modport slave (
        input  in_valid, fmt, rd, rs1, rs2, funct3, imm,
        input  load_addr, base_addr, out_ready, clear_err,
        output in_ready, out_valid, out_instr, out_addr, err_sticky, err_count
    );
endinterface
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : instr_encoder                                             |
// | Purpose  : Range-checks a signed immediate and scatters it with the  |
// |            register/funct3 fields into an RV32I word; legal words    |
// |            are queued with an auto-incrementing byte address.        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module instr_encoder #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 2
) (
    input  wire logic      clk,
    input  wire logic      rst,
    instr_encoder_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [PTR_W:0]    c_FULL    = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]    c_CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0]  c_PTR_ONE = PTR_W'(1);
    localparam logic [ADDR_W-1:0] c_STEP    = ADDR_W'(4);

    localparam logic [2:0] c_FMT_I    = 3'd0;
    localparam logic [2:0] c_FMT_S    = 3'd1;
    localparam logic [2:0] c_FMT_SB   = 3'd2;
    localparam logic [2:0] c_FMT_UJ   = 3'd3;
    localparam logic [2:0] c_FMT_JALR = 3'd4;
    localparam logic [2:0] c_FMT_U    = 3'd5;

    localparam logic [6:0] c_OP_I    = 7'b0010011;
    localparam logic [6:0] c_OP_S    = 7'b0100011;
    localparam logic [6:0] c_OP_SB   = 7'b1100011;
    localparam logic [6:0] c_OP_UJ   = 7'b1101111;
    localparam logic [6:0] c_OP_JALR = 7'b1100111;
    localparam logic [6:0] c_OP_U    = 7'b0110111;

    logic [31:0]       r_mem_instr [DEPTH];
    logic [ADDR_W-1:0] r_mem_addr  [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [PTR_W:0]    r_count;
    logic [ADDR_W-1:0] r_addr;
    logic              r_err_sticky;
    logic [7:0]        r_err_count;

    logic signed [31:0] w_imm;
    logic               w_fits12;
    logic               w_fits13;
    logic               w_fits21;
    logic               w_even;
    logic [31:0]        w_word;
    logic               w_legal;
    logic               w_full;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;

    assign w_imm    = bus.imm;
    assign w_fits12 = (w_imm >= -32'sd2048)    && (w_imm <= 32'sd2047);
    assign w_fits13 = (w_imm >= -32'sd4096)    && (w_imm <= 32'sd4094);
    assign w_fits21 = (w_imm >= -32'sd1048576) && (w_imm <= 32'sd1048574);
    assign w_even   = ~bus.imm[0];

    // Scatter the immediate into the format's bit positions and decide legality
    always_comb begin
        w_word  = 32'd0;
        w_legal = 1'b0;
        case (bus.fmt)
            c_FMT_I: begin
                w_word  = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, c_OP_I};
                w_legal = w_fits12;
            end
            c_FMT_JALR: begin
                // JALR has only one defined funct3 encoding
                w_word  = {bus.imm[11:0], bus.rs1, 3'b000, bus.rd, c_OP_JALR};
                w_legal = w_fits12;
            end
            c_FMT_S: begin
                w_word  = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3,
                           bus.imm[4:0], c_OP_S};
                w_legal = w_fits12;
            end
            c_FMT_SB: begin
                w_word  = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                           bus.imm[4:1], bus.imm[11], c_OP_SB};
                w_legal = w_fits13 && w_even;
            end
            c_FMT_UJ: begin
                w_word  = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12],
                           bus.rd, c_OP_UJ};
                w_legal = w_fits21 && w_even;
            end
            c_FMT_U: begin
                w_word  = {bus.imm[31:12], bus.rd, c_OP_U};
                w_legal = (bus.imm[11:0] == 12'd0);
            end
            default: begin
                w_word  = 32'd0;
                w_legal = 1'b0;
            end
        endcase
    end

    assign w_full       = (r_count == c_FULL);
    assign bus.in_ready = !w_full && !bus.load_addr && !rst;
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_push       = w_accept && w_legal;
    assign w_pop        = bus.out_valid && bus.out_ready;

    assign bus.out_valid  = (r_count != '0);
    assign bus.out_instr  = r_mem_instr[r_rptr];
    assign bus.out_addr   = r_mem_addr[r_rptr];
    assign bus.err_sticky = r_err_sticky;
    assign bus.err_count  = r_err_count;

    // Output FIFO: storage, pointers and occupancy; entries are cleared on reset
    // so the head reads zero until the first push
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_instr[i] <= 32'd0;
                r_mem_addr[i]  <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem_instr[r_wptr] <= w_word;
                r_mem_addr[r_wptr]  <= r_addr;
                r_wptr              <= r_wptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Byte address counter: load wins, otherwise advance one word per push
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= '0;
        end else if (bus.load_addr) begin
            r_addr <= bus.base_addr;
        end else if (w_push) begin
            r_addr <= r_addr + c_STEP;
        end
    end

    // Error flag and saturating reject counter; a clear in the same cycle wins
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_sticky <= 1'b0;
            r_err_count  <= 8'd0;
        end else if (bus.clear_err) begin
            r_err_sticky <= 1'b0;
            r_err_count  <= 8'd0;
        end else if (w_accept && !w_legal) begin
            r_err_sticky <= 1'b1;
            if (r_err_count != 8'hFF) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end
endmodule
`default_nettype wire
